shift_add_mul_seq: RTL

- Multi-cycle unsigned 32x32->64 multiplier sequencer built around one shared 32-bit ripple-carry adder (the team's thirty_two_bit_full_adder, 4-bit slices).
- Performs one conditional add plus one right shift per cycle over 32 iterations.
- Uses valid/ready handshakes on the operand and result sides.
- Sits beside the ALU as the MUL execution unit, so the ALU needs no combinational multiplier.

---
 rtl/shift_add_mul_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/shift_add_mul_seq.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one conditional add and one right shift per cycle
// through a shared ripple-carry adder, with valid/ready handshakes on operands and result.

// One 4-bit ripple-carry slice of the shared adder.
module four_bit_adder_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);
  logic [4:0] carry_s;

  assign carry_s[0] = carry_in;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]         = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end
  assign carry_out = carry_s[4];
endmodule

// 32-bit ripple-carry adder built from eight 4-bit slices.
module thirty_two_bit_full_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out
);
  logic [8:0] slice_c_s;

  assign slice_c_s[0] = carry_in;
  for (genvar g = 0; g < 8; g++) begin : g_slice
    four_bit_adder_slice u_slice (
      .a         (a[4*g+3:4*g]),
      .b         (b[4*g+3:4*g]),
      .carry_in  (slice_c_s[g]),
      .sum       (sum[4*g+3:4*g]),
      .carry_out (slice_c_s[g+1])
    );
  end
  assign carry_out = slice_c_s[8];
endmodule

module shift_add_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow,
  output logic               busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   count_r;
  logic [WIDTH-1:0]   mcand_r;
  // Bit 64 of the accumulator is always zero after a shift, so only 64 bits are kept.
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_shift_s;
  logic [WIDTH-1:0]   add_b_s;
  logic [WIDTH-1:0]   sum_s;
  logic               cout_s;
  logic               accept_s;
  logic               last_iter_s;
  logic               start_ready_r;
  logic               result_valid_r;
  logic               busy_r;
  logic [2*WIDTH-1:0] product_r;
  logic               overflow_r;

  assign add_b_s     = acc_r[0] ? mcand_r : {WIDTH{1'b0}};
  assign acc_shift_s = {cout_s, sum_s, acc_r[WIDTH-1:1]};
  assign accept_s    = (state_r == IDLE) && start_valid;
  assign last_iter_s = (count_r == CNT_W'(WIDTH - 1));

  thirty_two_bit_full_adder u_adder (
    .a         (acc_r[2*WIDTH-1:WIDTH]),
    .b         (add_b_s),
    .carry_in  (1'b0),
    .sum       (sum_s),
    .carry_out (cout_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (last_iter_s) state_s = DONE;
        else             state_s = CALC;
      end
      DONE: begin
        if (result_ready) state_s = IDLE;
        else              state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      start_ready_r  <= 1'b1;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      start_ready_r  <= (state_s == IDLE);
      result_valid_r <= (state_s == DONE);
      busy_r         <= (state_s == CALC);
    end
  end

  // Datapath: operand capture, add-and-shift iterations, result capture on the last iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= {CNT_W{1'b0}};
      mcand_r    <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      product_r  <= {(2*WIDTH){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r <= multiplicand;
            acc_r   <= {{WIDTH{1'b0}}, multiplier};
            count_r <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          acc_r   <= acc_shift_s;
          count_r <= count_r + CNT_W'(1);
          if (last_iter_s) begin
            product_r  <= acc_shift_s;
            overflow_r <= |acc_shift_s[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign start_ready  = start_ready_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign product      = product_r;
  assign overflow     = overflow_r;
endmodule
